// File: rtl/rv_pkg.sv
// Shared RISC-V load/store definitions: funct3 size codes, LSU state
// encoding, and helpers that decode funct3 into access size and legality.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic int f3_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  // Whether funct3 names a real load or store for the given datapath width.
  function automatic logic f3_legal(input logic [2:0] f3, input logic store,
                                    input int xlen);
    if (store) begin
      case (f3)
        F3_B, F3_H, F3_W: return 1'b1;
        F3_D:             return (xlen == 64);
        default:          return 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
        F3_D, F3_WU:                    return (xlen == 64);
        default:                        return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed bytes down to bit 0, truncates
// to the access size and sign- or zero-extends to XLEN. Purely combinational.
module lsu_load_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           rdata,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           data
);

  localparam int IW = $clog2(XLEN);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] size_mask;
  logic [IW-1:0]   sign_idx;
  logic            sign_ext;
  int              nbits;

  // Shift, mask to access width, then fill the upper bits with the sign bit
  // for signed loads (funct3[2]==0).
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    nbits     = 8 * f3_bytes(funct3);
    shifted   = rdata >> {off, 3'b000};
    size_mask = '1;
    sign_idx  = IW'(XLEN - 1);
    if (nbits < XLEN) begin
      size_mask = (XLEN'(1) << nbits) - XLEN'(1);
      sign_idx  = IW'(nbits - 1);
    end
    sign_ext = !funct3[2] && shifted[sign_idx];
    data     = (shifted & size_mask) | (sign_ext ? ~size_mask : '0);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request over a
// valid/ready bus, with byte strobes for stores and extended data for loads.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses complete with an
// error instead of being forced to natural alignment.
module lsu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_funct3,
  input  logic              req_store,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t      state;
  logic [OFFW-1:0] off_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;

  logic [OFFW-1:0] off_raw;
  logic [OFFW-1:0] off_lo_mask;
  logic [OFFW-1:0] off_eff;
  logic            acc_err;
  logic [NB-1:0]   strb;
  logic [XLEN-1:0] data_mask;
  logic [XLEN-1:0] wdata_lanes;
  logic [XLEN-1:0] ld_data;
  int              nbytes;

  // Decode the incoming request: legality, effective offset, strobes and lane data.
  always_comb begin
    nbytes      = f3_bytes(req_funct3);
    off_raw     = req_addr[OFFW-1:0];
    off_lo_mask = OFFW'(nbytes - 1);
    off_eff     = off_raw & ~off_lo_mask;
`ifdef LSU_MISALIGN_TRAP_EN
    acc_err     = !f3_legal(req_funct3, req_store, XLEN) ||
                  ((off_raw & off_lo_mask) != '0);
`else
    acc_err     = !f3_legal(req_funct3, req_store, XLEN);
`endif
    strb        = NB'((32'd1 << nbytes) - 32'd1) << off_eff;
    data_mask   = '1;
    if (8 * nbytes < XLEN) data_mask = (XLEN'(1) << (8 * nbytes)) - XLEN'(1);
    wdata_lanes = (req_wdata & data_mask) << {off_eff, 3'b000};
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (ld_data)
  );

  // Transaction FSM; all bus and writeback outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wstrb     <= '0;
      mem_wdata     <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_rd        <= '0;
      rsp_err       <= 1'b0;
      off_q         <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= off_eff;
            funct3_q  <= req_funct3;
            rd_q      <= req_rd;
            if (acc_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_rd    <= req_store ? 5'd0 : req_rd;
              state     <= ST_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
              mem_we        <= req_store;
              mem_wstrb     <= req_store ? strb : '0;
              mem_wdata     <= req_store ? wdata_lanes : '0;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_we) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= '0;
              rsp_rd    <= '0;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= ld_data;
            rsp_rd    <= rd_q;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu (XLEN=32): directed cases plus randomized
// transactions compared against a byte-arithmetic reference model.
module tb_lsu;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [2:0]        req_funct3;
  logic              req_store;
  logic [4:0]        req_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  lsu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .req_store(req_store),
    .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: access rules expressed as byte arithmetic ----
  function automatic int ref_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3, input bit store);
    // XLEN=32: only byte/half/word, unsigned variants for loads only
    if (store) return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
            f3 == 3'b100 || f3 == 3'b101);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_rd"}, rsp_rd, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // Run one full transaction, checking every cycle against the model.
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic do_txn(input string tag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input bit store, input logic [4:0] rd,
                        input logic [31:0] rdata, input int req_stall,
                        input int rsp_stall);
    int          nb;
    int          off;
    int          eff_off;
    bit          mis;
    bit          err;
    longint      v;
    logic [31:0] exp_addr;
    logic [31:0] exp_load;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;

    nb      = ref_bytes(f3);
    off     = int'(addr % 4);
    mis     = (off % nb) != 0;
    eff_off = off - (off % nb);
`ifdef LSU_MISALIGN_TRAP_EN
    err     = !ref_legal(f3, store) || mis;
`else
    err     = !ref_legal(f3, store);
`endif
    exp_addr  = addr - (addr % 4);
    exp_strb  = 4'(((64'd1 << nb) - 1) << eff_off);
    exp_wdata = 32'((longint'(wdata) & ((64'd1 << (8 * nb)) - 1)) << (8 * eff_off));
    v = (longint'(rdata) >> (8 * eff_off)) & ((64'd1 << (8 * nb)) - 1);
    if (f3[2] == 1'b0 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
    exp_load = 32'(v);

    check({tag, "_idle_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_store  = store;
    req_rd     = rd;
    @(negedge clk);  // cycle 1
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    check({tag, "_c1_ready"}, req_ready, 0);

    if (err) begin
      check({tag, "_err_valid"}, rsp_valid, 1);
      check({tag, "_err_flag"}, rsp_err, 1);
      check({tag, "_err_data"}, rsp_data, 0);
      check({tag, "_err_rd"}, rsp_rd, store ? 5'd0 : rd);
      check({tag, "_err_nobus"}, mem_req_valid, 0);
    end else begin
      check({tag, "_c1_reqv"}, mem_req_valid, 1);
      check({tag, "_c1_rspv"}, rsp_valid, 0);
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_we"}, mem_we, store);
      if (store) begin
        check({tag, "_wstrb"}, mem_wstrb, exp_strb);
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
      end
      for (int k = 0; k < req_stall; k++) begin
        mem_req_ready = 1'b0;
        @(negedge clk);
        check({tag, "_stall_reqv"}, mem_req_valid, 1);
        check({tag, "_stall_addr"}, mem_addr, exp_addr);
        check({tag, "_stall_ready"}, req_ready, 0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({tag, "_post_hs_reqv"}, mem_req_valid, 0);
      if (store) begin
        check({tag, "_st_valid"}, rsp_valid, 1);
        check({tag, "_st_err"}, rsp_err, 0);
        check({tag, "_st_data"}, rsp_data, 0);
        check({tag, "_st_rd"}, rsp_rd, 0);
      end else begin
        for (int k = 0; k < rsp_stall; k++) begin
          mem_rsp_valid = 1'b0;
          mem_rdata     = $urandom;
          @(negedge clk);
          check({tag, "_wait_rspv"}, rsp_valid, 0);
        end
        check({tag, "_wait_rspv0"}, rsp_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        check({tag, "_ld_valid"}, rsp_valid, 1);
        check({tag, "_ld_data"}, rsp_data, exp_load);
        check({tag, "_ld_rd"}, rsp_rd, rd);
        check({tag, "_ld_err"}, rsp_err, 0);
      end
    end
    check({tag, "_done_ready"}, req_ready, 0);
    @(negedge clk);
    check({tag, "_pulse_end"}, rsp_valid, 0);
    check({tag, "_back_ready"}, req_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_funct3    = '0;
    req_store     = 1'b0;
    req_rd        = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    do_txn("lw_aligned", 32'h0000_1004, 32'h0, 3'b010, 0, 5'd7, 32'hDEAD_BEEF, 0, 0);
    do_txn("lb_off3",    32'h0000_1003, 32'h0, 3'b000, 0, 5'd3, 32'h80FF_0000, 0, 0);
    do_txn("lbu_off3",   32'h0000_1003, 32'h0, 3'b100, 0, 5'd4, 32'h80FF_0000, 0, 0);
    do_txn("sh_off2",    32'h0000_2002, 32'h0000_ABCD, 3'b001, 1, 5'd9, 32'h0, 0, 0);
    do_txn("stall_lw",   32'h0000_3008, 32'h0, 3'b010, 0, 5'd1, 32'h1234_5678, 3, 2);
    do_txn("stall_sw",   32'h0000_300C, 32'hCAFE_F00D, 3'b010, 1, 5'd2, 32'h0, 3, 0);
    do_txn("lw_mis",     32'h0000_1001, 32'h0, 3'b010, 0, 5'd5, 32'hA5A5_5A5A, 0, 0);
    do_txn("lhu_mis",    32'h0000_1003, 32'h0, 3'b101, 0, 5'd6, 32'h8001_7F02, 1, 1);
    do_txn("sb_off1",    32'h0000_4001, 32'hFFFF_FF3C, 3'b000, 1, 5'd0, 32'h0, 0, 0);
    do_txn("ill_ld_d",   32'h0000_5000, 32'h0, 3'b011, 0, 5'd8, 32'h0, 0, 0);
    do_txn("ill_st_bu",  32'h0000_5000, 32'h1, 3'b100, 1, 5'd8, 32'h0, 0, 0);
    do_txn("ill_ld_111", 32'h0000_5000, 32'h0, 3'b111, 0, 5'd8, 32'h0, 0, 0);

    // randomized transactions
    for (int n = 0; n < 80; n++) begin
      do_txn("rand", $urandom, $urandom, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // reset asserted while a load waits for its response
    req_valid  = 1'b1;
    req_addr   = 32'h0000_6000;
    req_funct3 = 3'b010;
    req_store  = 1'b0;
    req_rd     = 5'd17;
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_wait_pre_reqv", mem_req_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1111_2222;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_wait_no_rsp", rsp_valid, 0);
      check("rst_wait_ready", req_ready, 1);
      @(negedge clk);
    end
    do_txn("post_rst_lh", 32'h0000_7002, 32'h0, 3'b001, 0, 5'd12, 32'h8421_0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
